// File: rtl/dpc_io_pkg.sv
// Shared types and constants for the DekatronPC character I/O path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dpc_io_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] ASCII_CR = 8'h0D;
    localparam logic [BYTE_W-1:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK_OUT = 2'd1,
        ACK_IN  = 2'd2,
        RELEASE = 2'd3
    } console_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with occupancy counter and a registered-state head output.
// Latency: a pushed byte is visible on pop_dat the cycle after the push edge.
// Backpressure: push ignored when full unless popped in the same cycle; pop ignored when empty.
module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    // Head reads zero when empty so the output is defined straight out of reset.
    assign pop_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dpc_console_port.sv
// Headless CioAcq responder: core bytes to a TX FIFO, host bytes from an RX FIFO to the core, optional echo.
// Latency: request sampled at edge N -> CioAcq (and stdin for input) during cycle N+1.
// Backpressure: core stalls without ack while TX is full or RX is empty; rx_ready drops when RX is full.
module dpc_console_port
    import dpc_io_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter bit ECHO_DEFAULT = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Cout,
    input  logic [BYTE_W-1:0] stdout,
    input  logic              CinReq,
    output logic [BYTE_W-1:0] stdin,
    output logic              CioAcq,
    input  logic              EchoEn,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              tx_overrun
);

    console_state_t    state;
    console_state_t    state_nxt;

    logic              tx_push;
    logic [BYTE_W-1:0] tx_push_dat;
    logic              tx_pop;
    logic              tx_full;
    logic              tx_empty;

    logic              rx_push;
    logic              rx_pop;
    logic [BYTE_W-1:0] rx_head;
    logic              rx_full;
    logic              rx_empty;

    logic              echo_flag;
    logic              echo_drop;

    assign tx_pop   = tx_ready & ~tx_empty;
    assign tx_valid = ~tx_empty;
    assign rx_ready = ~rx_full;
    assign rx_push  = rx_valid & ~rx_full;

    byte_fifo #(.DEPTH(FIFO_DEPTH), .W(BYTE_W)) u_tx_fifo (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .push     (tx_push),
        .push_dat (tx_push_dat),
        .pop      (tx_pop),
        .pop_dat  (tx_data),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH), .W(BYTE_W)) u_rx_fifo (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .push     (rx_push),
        .push_dat (rx_data),
        .pop      (rx_pop),
        .pop_dat  (rx_head),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (Cout) begin
                    if (!tx_full) begin
                        state_nxt = ACK_OUT;
                    end
                end else if (CinReq && !rx_empty) begin
                    state_nxt = ACK_IN;
                end
            end
            ACK_OUT: state_nxt = RELEASE;
            ACK_IN:  state_nxt = RELEASE;
            // Both requests must drop first, otherwise a held level would transfer twice.
            RELEASE: begin
                if (!Cout && !CinReq) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        CioAcq      = 1'b0;
        tx_push     = 1'b0;
        tx_push_dat = stdout;
        rx_pop      = 1'b0;
        echo_drop   = 1'b0;
        case (state)
            IDLE: begin
                if (Cout) begin
                    tx_push = ~tx_full;
                end else if (CinReq) begin
                    rx_pop = ~rx_empty;
                end
            end
            ACK_OUT: CioAcq = 1'b1;
            ACK_IN: begin
                CioAcq      = 1'b1;
                tx_push_dat = stdin;
                if (echo_flag) begin
                    tx_push   = ~tx_full;
                    echo_drop = tx_full;
                end
            end
            default: ;
        endcase
    end

    // EchoEn is captured with the byte, so one transfer sees one consistent echo decision.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stdin     <= '0;
            echo_flag <= ECHO_DEFAULT;
        end else if (rx_pop) begin
            stdin     <= rx_head;
            echo_flag <= EchoEn;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tx_overrun <= 1'b0;
        end else if (echo_drop) begin
            tx_overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dpc_console_port.sv
// Directed bench for dpc_console_port with a queue-based reference model and per-cycle compare.
module tb_dpc_console_port;
    import dpc_io_pkg::*;

    localparam int D = 8;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       Cout = 1'b0;
    logic [7:0] stdout = 8'h00;
    logic       CinReq = 1'b0;
    logic [7:0] stdin;
    logic       CioAcq;
    logic       EchoEn = 1'b1;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic       tx_overrun;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    dpc_console_port #(.FIFO_DEPTH(D), .ECHO_DEFAULT(1'b1)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Cout       (Cout),
        .stdout     (stdout),
        .CinReq     (CinReq),
        .stdin      (stdin),
        .CioAcq     (CioAcq),
        .EchoEn     (EchoEn),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_overrun (tx_overrun)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: byte queues plus the transfer rules (ack one cycle after a served
    // request, echo at the end of an input ack, no new transfer until both requests drop).
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    bit         m_acq = 0, m_in = 0, m_wait = 0, m_echo = 0, m_ovr = 0;
    logic [7:0] m_stdin = 8'h00;
    int         m_txn, m_rxn;
    bit         m_push, m_new;
    logic [7:0] m_pv;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            txq.delete();
            rxq.delete();
            m_acq = 0; m_in = 0; m_wait = 0; m_echo = 0; m_ovr = 0;
            m_stdin = 8'h00;
        end else begin
            m_txn  = txq.size();
            m_rxn  = rxq.size();
            m_push = 0;
            m_new  = 0;
            m_pv   = 8'h00;
            if (m_acq) begin
                if (m_in && m_echo) begin
                    if (m_txn < D) begin m_push = 1; m_pv = m_stdin; end
                    else m_ovr = 1;
                end
                m_wait = 1;
            end else if (m_wait) begin
                if (!Cout && !CinReq) m_wait = 0;
            end else if (Cout) begin
                if (m_txn < D) begin m_push = 1; m_pv = stdout; m_new = 1; m_in = 0; end
            end else if (CinReq && m_rxn > 0) begin
                m_stdin = rxq.pop_front();
                m_echo  = EchoEn;
                m_new   = 1;
                m_in    = 1;
            end
            if (rx_valid && m_rxn < D) rxq.push_back(rx_data);
            if (tx_ready && m_txn > 0) void'(txq.pop_front());
            if (m_push) txq.push_back(m_pv);
            m_acq = m_new;
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            check("cmp_cioacq", CioAcq, m_acq);
            check("cmp_stdin", stdin, m_stdin);
            check("cmp_tx_valid", tx_valid, txq.size() != 0);
            if (txq.size() != 0) check("cmp_tx_data", tx_data, txq[0]);
            check("cmp_rx_ready", rx_ready, rxq.size() < D);
            check("cmp_tx_overrun", tx_overrun, m_ovr);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #2;
        end
    endtask

    task automatic wait_ack(input int max, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (CioAcq !== 1'b1 && n < max);
        if (CioAcq !== 1'b1) n = -1;
    endtask

    task automatic core_out(input logic [7:0] b, output int n);
        Cout = 1'b1;
        stdout = b;
        wait_ack(20, n);
        Cout = 1'b0;
        step(2);
    endtask

    task automatic host_send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data = b;
        step(1);
        rx_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int acks;

        step(3);
        check("rst_cioacq", CioAcq, 1'b0);
        check("rst_stdin", stdin, 8'h00);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_rx_ready", rx_ready, 1'b1);
        check("rst_tx_overrun", tx_overrun, 1'b0);
        Rst_n = 1'b1;
        chk_en = 1'b1;
        step(2);

        // 1: output transfer, single ack on a held request
        Cout = 1'b1;
        stdout = 8'h41;
        step(1);
        check("t1_ack", CioAcq, 1'b1);
        check("t1_tx_data", tx_data, 8'h41);
        check("t1_tx_valid", tx_valid, 1'b1);
        acks = 0;
        repeat (5) begin step(1); if (CioAcq) acks++; end
        check("t1_no_double_ack", acks, 0);
        Cout = 1'b0;
        step(2);
        tx_ready = 1'b1;
        step(1);
        tx_ready = 1'b0;
        check("t1_drained", tx_valid, 1'b0);

        // 2: input with echo
        EchoEn = 1'b1;
        host_send(8'h35);
        CinReq = 1'b1;
        step(1);
        check("t2_ack", CioAcq, 1'b1);
        check("t2_stdin", stdin, 8'h35);
        step(1);
        check("t2_echo_valid", tx_valid, 1'b1);
        check("t2_echo_data", tx_data, 8'h35);
        check("t2_rx_ready", rx_ready, 1'b1);
        CinReq = 1'b0;
        step(2);
        tx_ready = 1'b1;
        step(1);
        tx_ready = 1'b0;

        // 3: input stall on empty RX, then ack two cycles after the host handshake
        EchoEn = 1'b0;
        CinReq = 1'b1;
        acks = 0;
        repeat (20) begin step(1); if (CioAcq) acks++; end
        check("t3_stall", acks, 0);
        host_send(ASCII_LF);
        check("t3_not_yet", CioAcq, 1'b0);
        step(1);
        check("t3_ack", CioAcq, 1'b1);
        check("t3_stdin", stdin, 8'h0A);
        CinReq = 1'b0;
        step(2);

        // 4: TX backpressure
        for (int i = 0; i < 8; i++) begin
            core_out(8'(8'h50 + i), n);
            check("t4_ack", n, 1);
        end
        Cout = 1'b1;
        stdout = 8'h58;
        acks = 0;
        repeat (5) begin step(1); if (CioAcq) acks++; end
        check("t4_full_stall", acks, 0);
        tx_ready = 1'b1;
        step(1);
        tx_ready = 1'b0;
        wait_ack(10, n);
        check("t4_ack9", n, 1);
        Cout = 1'b0;
        step(2);
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("t4_order", tx_data, 8'(8'h50 + i));
            step(1);
        end
        tx_ready = 1'b0;
        check("t4_empty", tx_valid, 1'b0);

        // 5: echo overrun with TX full, then output priority
        for (int i = 0; i < 8; i++) core_out(8'(8'h60 + i), n);
        EchoEn = 1'b1;
        host_send(8'h33);
        CinReq = 1'b1;
        wait_ack(5, n);
        check("t5_ack", n, 1);
        check("t5_stdin", stdin, 8'h33);
        step(1);
        check("t5_overrun", tx_overrun, 1'b1);
        check("t5_head", tx_data, 8'h60);
        CinReq = 1'b0;
        step(2);
        tx_ready = 1'b1;
        step(8);
        tx_ready = 1'b0;
        host_send(8'h34);
        Cout = 1'b1;
        CinReq = 1'b1;
        stdout = 8'h70;
        step(1);
        check("t5_prio_ack", CioAcq, 1'b1);
        check("t5_prio_tx", tx_data, 8'h70);
        check("t5_prio_stdin", stdin, 8'h33);
        Cout = 1'b0;
        acks = 0;
        repeat (3) begin step(1); if (CioAcq) acks++; end
        check("t5_hold_cinreq", acks, 0);
        CinReq = 1'b0;
        step(2);
        CinReq = 1'b1;
        step(1);
        check("t5_in_ack", CioAcq, 1'b1);
        check("t5_in_stdin", stdin, 8'h34);
        CinReq = 1'b0;
        step(2);

        // 6: reset during ACK_IN
        host_send(8'h55);
        CinReq = 1'b1;
        step(1);
        check("t6_ack", CioAcq, 1'b1);
        #1 Rst_n = 1'b0;
        #1;
        check("t6_rst_cioacq", CioAcq, 1'b0);
        check("t6_rst_tx_valid", tx_valid, 1'b0);
        check("t6_rst_overrun", tx_overrun, 1'b0);
        check("t6_rst_stdin", stdin, 8'h00);
        CinReq = 1'b0;
        step(2);
        Rst_n = 1'b1;
        step(2);
        check("t6_tx_empty", tx_valid, 1'b0);
        check("t6_rx_ready", rx_ready, 1'b1);
        CinReq = 1'b1;
        acks = 0;
        repeat (4) begin step(1); if (CioAcq) acks++; end
        check("t6_rx_dropped", acks, 0);
        CinReq = 1'b0;
        step(2);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
